// File: rtl/dma_txq_pkt_reader.sv
// Pulls one packet at a time from the CPU TX queue and forwards it word by word to the DMA engine.
// Packets longer than MAX_PKT_WORDS are cut short, flagged as errors, and their tail is drained from the queue.
module dma_txq_pkt_reader #(
    parameter int DMA_DATA_WIDTH = 32,
    parameter int DMA_CTRL_WIDTH = DMA_DATA_WIDTH / 8,
    parameter int MAX_PKT_WORDS  = 384
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      cpu_q_dma_pkt_avail,
    input  logic                      cpu_q_dma_rd_rdy,
    output logic                      cpu_q_dma_rd,
    input  logic [DMA_DATA_WIDTH-1:0] cpu_q_dma_rd_data,
    input  logic [DMA_CTRL_WIDTH-1:0] cpu_q_dma_rd_ctrl,
    output logic [DMA_DATA_WIDTH-1:0] xfer_data,
    output logic                      xfer_vld,
    output logic                      xfer_last,
    input  logic                      xfer_rdy,
    output logic [11:0]               pkt_len,
    output logic                      pkt_len_vld,
    output logic                      pkt_err,
    output logic [15:0]               pkt_cnt
);

    localparam int WCNT_W  = $clog2(MAX_PKT_WORDS + 1);
    localparam int BYTES_W = $clog2(DMA_CTRL_WIDTH + 1);
    localparam logic [DMA_CTRL_WIDTH-1:0] CTRL_ONE = {{(DMA_CTRL_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, READ, DISCARD, DONE} state_e;

    state_e                    state_q, state_d;
    logic                      rd_pend_q, rd_pend_d;
    logic                      eop_q, eop_d;
    logic [DMA_DATA_WIDTH-1:0] xfer_data_q, xfer_data_d;
    logic                      xfer_vld_q, xfer_vld_d;
    logic                      xfer_last_q, xfer_last_d;
    logic [11:0]               pkt_len_q, pkt_len_d;
    logic                      pkt_err_q, pkt_err_d;
    logic [15:0]               pkt_cnt_q, pkt_cnt_d;
    logic [WCNT_W-1:0]         wcnt_q, wcnt_d;

    logic                      accept;
    logic                      ctrl_last;
    logic                      at_max;
    logic [BYTES_W-1:0]        last_bytes;

    // One-hot ctrl marks the final valid byte (MSB = first byte); anything else means a full word.
    always_comb begin
        last_bytes = BYTES_W'(DMA_CTRL_WIDTH);
        for (int k = 0; k < DMA_CTRL_WIDTH; k++) begin
            if (cpu_q_dma_rd_ctrl == (CTRL_ONE << (DMA_CTRL_WIDTH - 1 - k)))
                last_bytes = BYTES_W'(k + 1);
        end
    end

    assign accept    = xfer_vld_q & xfer_rdy;
    assign ctrl_last = |cpu_q_dma_rd_ctrl;
    assign at_max    = (wcnt_q == WCNT_W'(MAX_PKT_WORDS - 1));

    always_comb begin
        state_d      = state_q;
        eop_d        = eop_q;
        xfer_data_d  = xfer_data_q;
        xfer_vld_d   = xfer_vld_q;
        xfer_last_d  = xfer_last_q;
        pkt_len_d    = pkt_len_q;
        pkt_err_d    = pkt_err_q;
        pkt_cnt_d    = pkt_cnt_q;
        wcnt_d       = wcnt_q;
        cpu_q_dma_rd = 1'b0;
        pkt_len_vld  = 1'b0;

        if (accept) xfer_vld_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && cpu_q_dma_pkt_avail && cpu_q_dma_rd_rdy) begin
                    state_d = READ;
                    wcnt_d  = '0;
                    eop_d   = 1'b0;
                end
            end
            READ: begin
                // A read is only issued when its word is guaranteed a free output register.
                cpu_q_dma_rd = cpu_q_dma_rd_rdy & ~rd_pend_q & ~eop_q & (~xfer_vld_q | accept);
                if (rd_pend_q) begin
                    xfer_data_d = cpu_q_dma_rd_data;
                    xfer_vld_d  = 1'b1;
                    xfer_last_d = ctrl_last | at_max;
                    wcnt_d      = wcnt_q + 1'b1;
                    if (ctrl_last) begin
                        eop_d     = 1'b1;
                        pkt_len_d = 12'(wcnt_q) * 12'(DMA_CTRL_WIDTH) + 12'(last_bytes);
                    end else if (at_max) begin
                        eop_d     = 1'b1;
                        pkt_err_d = 1'b1;
                        pkt_len_d = 12'(MAX_PKT_WORDS * DMA_CTRL_WIDTH);
                    end
                end
                if (accept && xfer_last_q) begin
                    xfer_last_d = 1'b0;
                    eop_d       = 1'b0;
                    state_d     = pkt_err_q ? DISCARD : DONE;
                end
            end
            DISCARD: begin
                cpu_q_dma_rd = cpu_q_dma_rd_rdy & ~rd_pend_q & ~eop_q;
                if (rd_pend_q && ctrl_last) state_d = DONE;
            end
            DONE: begin
                pkt_len_vld = 1'b1;
                pkt_cnt_d   = pkt_cnt_q + 16'd1;
                pkt_err_d   = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reads are never issued while one is pending, so the pending flag is just last cycle's strobe.
    assign rd_pend_d = cpu_q_dma_rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rd_pend_q   <= 1'b0;
            eop_q       <= 1'b0;
            xfer_data_q <= '0;
            xfer_vld_q  <= 1'b0;
            xfer_last_q <= 1'b0;
            pkt_len_q   <= '0;
            pkt_err_q   <= 1'b0;
            pkt_cnt_q   <= '0;
            wcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            rd_pend_q   <= rd_pend_d;
            eop_q       <= eop_d;
            xfer_data_q <= xfer_data_d;
            xfer_vld_q  <= xfer_vld_d;
            xfer_last_q <= xfer_last_d;
            pkt_len_q   <= pkt_len_d;
            pkt_err_q   <= pkt_err_d;
            pkt_cnt_q   <= pkt_cnt_d;
            wcnt_q      <= wcnt_d;
        end
    end

    assign xfer_data = xfer_data_q;
    assign xfer_vld  = xfer_vld_q;
    assign xfer_last = xfer_last_q;
    assign pkt_len   = pkt_len_q;
    assign pkt_err   = pkt_err_q;
    assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_dma_txq_pkt_reader.sv
// Directed bench for dma_txq_pkt_reader: queue responder model, accepted-word capture, per-scenario checks.
module tb_dma_txq_pkt_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        cpu_q_dma_pkt_avail = 1'b0;
    logic        cpu_q_dma_rd_rdy = 1'b1;
    logic        cpu_q_dma_rd;
    logic [31:0] cpu_q_dma_rd_data = 32'hDEADBEEF;
    logic [3:0]  cpu_q_dma_rd_ctrl = 4'hF;
    logic [31:0] xfer_data;
    logic        xfer_vld;
    logic        xfer_last;
    logic        xfer_rdy = 1'b1;
    logic [11:0] pkt_len;
    logic        pkt_len_vld;
    logic        pkt_err;
    logic [15:0] pkt_cnt;

    dma_txq_pkt_reader dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .cpu_q_dma_pkt_avail(cpu_q_dma_pkt_avail), .cpu_q_dma_rd_rdy(cpu_q_dma_rd_rdy),
        .cpu_q_dma_rd(cpu_q_dma_rd), .cpu_q_dma_rd_data(cpu_q_dma_rd_data),
        .cpu_q_dma_rd_ctrl(cpu_q_dma_rd_ctrl), .xfer_data(xfer_data), .xfer_vld(xfer_vld),
        .xfer_last(xfer_last), .xfer_rdy(xfer_rdy), .pkt_len(pkt_len),
        .pkt_len_vld(pkt_len_vld), .pkt_err(pkt_err), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int errs = 0;

    logic [31:0] mem_data [0:511];
    logic [3:0]  mem_ctrl [0:511];
    logic [31:0] cap_data [0:1023];
    logic        cap_last [0:1023];
    int cap_count = 0, rd_count = 0, overlap = 0, bad_rdy = 0, fire_idx = 0;
    int start_rd = 0, start_cap = 0;
    logic fire = 1'b0, prev_rd = 1'b0;

    // Sample DUT at the falling edge: handshakes seen here complete on the next rising edge.
    always @(negedge clk) begin
        if (xfer_vld && xfer_rdy && cap_count < 1024) begin
            cap_data[cap_count] <= xfer_data;
            cap_last[cap_count] <= xfer_last;
            cap_count <= cap_count + 1;
        end
        if (cpu_q_dma_rd) begin
            rd_count <= rd_count + 1;
            fire     <= 1'b1;
            fire_idx <= rd_count - start_rd;
            if (!cpu_q_dma_rd_rdy) bad_rdy <= bad_rdy + 1;
            if (prev_rd) overlap <= overlap + 1;
        end else begin
            fire <= 1'b0;
        end
        prev_rd <= cpu_q_dma_rd;
    end

    // Queue returns the word one cycle after the read; garbage otherwise.
    always @(posedge clk) begin
        if (fire && fire_idx < 512) begin
            cpu_q_dma_rd_data <= mem_data[fire_idx];
            cpu_q_dma_rd_ctrl <= mem_ctrl[fire_idx];
        end else begin
            cpu_q_dma_rd_data <= 32'hDEADBEEF;
            cpu_q_dma_rd_ctrl <= 4'hF;
        end
    end

    task automatic fill(input int n, input logic [3:0] lctrl, input logic [31:0] seed);
        for (int i = 0; i < 512; i++) begin
            mem_data[i] = seed + i;
            mem_ctrl[i] = (i == n - 1) ? lctrl : 4'h0;
        end
    endtask

    task automatic run_pkt(input int n, input logic [3:0] lctrl, input logic [31:0] seed,
                           input bit toggle, input int stall_at, input int en_drop,
                           output bit done, output logic [11:0] len, output logic err,
                           output int nstall);
        int cyc;
        fill(n, lctrl, seed);
        start_rd  = rd_count;
        start_cap = cap_count;
        done = 0; len = '0; err = 1'b0; nstall = 0; cyc = 0;
        cpu_q_dma_pkt_avail = 1'b1;
        enable = 1'b1;
        cpu_q_dma_rd_rdy = 1'b1;
        xfer_rdy = 1'b1;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            if (pkt_len_vld) begin done = 1; len = pkt_len; err = pkt_err; end
            @(posedge clk); #1;
            cyc++;
            xfer_rdy = toggle ? ~xfer_rdy : 1'b1;
            if (stall_at >= 0 && rd_count - start_rd >= stall_at && nstall < 5) begin
                cpu_q_dma_rd_rdy = 1'b0; nstall++;
            end else begin
                cpu_q_dma_rd_rdy = 1'b1;
            end
            if (en_drop >= 0 && rd_count - start_rd >= en_drop) enable = 1'b0;
        end
        cpu_q_dma_pkt_avail = 1'b0;
        cpu_q_dma_rd_rdy = 1'b1;
        xfer_rdy = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; cpu_q_dma_pkt_avail = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vec++; if (cpu_q_dma_rd !== 1'b0) begin errs++; $display("FAIL reset_rd got=%b exp=0", cpu_q_dma_rd); end
        vec++; if (xfer_vld !== 1'b0) begin errs++; $display("FAIL reset_xfer_vld got=%b exp=0", xfer_vld); end
        vec++; if (xfer_last !== 1'b0) begin errs++; $display("FAIL reset_xfer_last got=%b exp=0", xfer_last); end
        vec++; if (pkt_len_vld !== 1'b0) begin errs++; $display("FAIL reset_pkt_len_vld got=%b exp=0", pkt_len_vld); end
        vec++; if (pkt_err !== 1'b0) begin errs++; $display("FAIL reset_pkt_err got=%b exp=0", pkt_err); end
        vec++; if (xfer_data !== 32'h0) begin errs++; $display("FAIL reset_xfer_data got=%h exp=0", xfer_data); end
        vec++; if (pkt_len !== 12'h0) begin errs++; $display("FAIL reset_pkt_len got=%0d exp=0", pkt_len); end
        vec++; if (pkt_cnt !== 16'h0) begin errs++; $display("FAIL reset_pkt_cnt got=%0d exp=0", pkt_cnt); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        vec++; if (cpu_q_dma_rd !== 1'b0) begin errs++; $display("FAIL reset_first_rd got=%b exp=0", cpu_q_dma_rd); end
        cpu_q_dma_pkt_avail = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit done; logic [11:0] len; logic err; int ns;
        run_pkt(3, 4'b0010, 32'h1000_0000, 1'b0, -1, -1, done, len, err, ns);
        vec++; if (done !== 1'b1) begin errs++; $display("FAIL basic_done got=%b exp=1 (timeout)", done); end
        vec++; if (cap_count - start_cap !== 3) begin errs++; $display("FAIL basic_words got=%0d exp=3", cap_count - start_cap); end
        for (int i = 0; i < 3; i++) begin
            vec++; if (cap_data[start_cap+i] !== 32'h1000_0000 + i) begin errs++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, cap_data[start_cap+i], 32'h1000_0000 + i); end
            vec++; if (cap_last[start_cap+i] !== (i == 2)) begin errs++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, cap_last[start_cap+i], i == 2); end
        end
        vec++; if (len !== 12'd11) begin errs++; $display("FAIL basic_len got=%0d exp=11", len); end
        vec++; if (err !== 1'b0) begin errs++; $display("FAIL basic_err got=%b exp=0", err); end
        vec++; if (pkt_cnt !== 16'd1) begin errs++; $display("FAIL basic_cnt got=%0d exp=1", pkt_cnt); end
        vec++; if (pkt_len_vld !== 1'b0) begin errs++; $display("FAIL basic_len_vld_width got=%b exp=0", pkt_len_vld); end
        vec++; if (rd_count - start_rd !== 3) begin errs++; $display("FAIL basic_reads got=%0d exp=3", rd_count - start_rd); end
    endtask

    task automatic test_rdy_toggle();
        bit done; logic [11:0] len; logic err; int ns;
        run_pkt(3, 4'b0010, 32'h2000_0000, 1'b1, -1, -1, done, len, err, ns);
        vec++; if (done !== 1'b1) begin errs++; $display("FAIL toggle_done got=%b exp=1 (timeout)", done); end
        vec++; if (cap_count - start_cap !== 3) begin errs++; $display("FAIL toggle_words got=%0d exp=3", cap_count - start_cap); end
        for (int i = 0; i < 3; i++) begin
            vec++; if (cap_data[start_cap+i] !== 32'h2000_0000 + i) begin errs++; $display("FAIL toggle_data[%0d] got=%h exp=%h", i, cap_data[start_cap+i], 32'h2000_0000 + i); end
        end
        vec++; if (len !== 12'd11) begin errs++; $display("FAIL toggle_len got=%0d exp=11", len); end
        vec++; if (overlap !== 0) begin errs++; $display("FAIL toggle_outstanding got=%0d exp=0", overlap); end
        vec++; if (pkt_cnt !== 16'd2) begin errs++; $display("FAIL toggle_cnt got=%0d exp=2", pkt_cnt); end
    endtask

    task automatic test_truncate();
        bit done; logic [11:0] len; logic err; int ns; int nlast;
        run_pkt(400, 4'b0001, 32'h3000_0000, 1'b0, -1, -1, done, len, err, ns);
        vec++; if (done !== 1'b1) begin errs++; $display("FAIL trunc_done got=%b exp=1 (timeout)", done); end
        vec++; if (cap_count - start_cap !== 384) begin errs++; $display("FAIL trunc_words got=%0d exp=384", cap_count - start_cap); end
        nlast = 0;
        for (int i = 0; i < 384; i++) begin
            vec++; if (cap_data[start_cap+i] !== 32'h3000_0000 + i) begin errs++; $display("FAIL trunc_data[%0d] got=%h exp=%h", i, cap_data[start_cap+i], 32'h3000_0000 + i); end
            if (cap_last[start_cap+i] === 1'b1) nlast++;
        end
        vec++; if (cap_last[start_cap+383] !== 1'b1) begin errs++; $display("FAIL trunc_last384 got=%b exp=1", cap_last[start_cap+383]); end
        vec++; if (nlast !== 1) begin errs++; $display("FAIL trunc_last_count got=%0d exp=1", nlast); end
        vec++; if (rd_count - start_rd !== 400) begin errs++; $display("FAIL trunc_reads got=%0d exp=400", rd_count - start_rd); end
        vec++; if (len !== 12'd1536) begin errs++; $display("FAIL trunc_len got=%0d exp=1536", len); end
        vec++; if (err !== 1'b1) begin errs++; $display("FAIL trunc_err got=%b exp=1", err); end
        vec++; if (pkt_err !== 1'b0) begin errs++; $display("FAIL trunc_err_clear got=%b exp=0", pkt_err); end
        vec++; if (pkt_cnt !== 16'd3) begin errs++; $display("FAIL trunc_cnt got=%0d exp=3", pkt_cnt); end
    endtask

    task automatic test_rd_stall();
        bit done; logic [11:0] len; logic err; int ns;
        run_pkt(6, 4'b1000, 32'h4000_0000, 1'b0, 2, -1, done, len, err, ns);
        vec++; if (done !== 1'b1) begin errs++; $display("FAIL stall_done got=%b exp=1 (timeout)", done); end
        vec++; if (ns !== 5) begin errs++; $display("FAIL stall_cycles got=%0d exp=5", ns); end
        vec++; if (bad_rdy !== 0) begin errs++; $display("FAIL stall_rd_while_not_rdy got=%0d exp=0", bad_rdy); end
        vec++; if (cap_count - start_cap !== 6) begin errs++; $display("FAIL stall_words got=%0d exp=6", cap_count - start_cap); end
        for (int i = 0; i < 6; i++) begin
            vec++; if (cap_data[start_cap+i] !== 32'h4000_0000 + i) begin errs++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, cap_data[start_cap+i], 32'h4000_0000 + i); end
        end
        vec++; if (len !== 12'd21) begin errs++; $display("FAIL stall_len got=%0d exp=21", len); end
        vec++; if (pkt_cnt !== 16'd4) begin errs++; $display("FAIL stall_cnt got=%0d exp=4", pkt_cnt); end
    endtask

    task automatic test_enable();
        bit done; logic [11:0] len; logic err; int ns; int snap;
        enable = 1'b0; cpu_q_dma_pkt_avail = 1'b1;
        snap = rd_count;
        repeat (10) @(posedge clk);
        #1;
        vec++; if (rd_count !== snap) begin errs++; $display("FAIL enable_off_reads got=%0d exp=%0d", rd_count, snap); end
        run_pkt(4, 4'b0100, 32'h5000_0000, 1'b0, -1, 1, done, len, err, ns);
        vec++; if (done !== 1'b1) begin errs++; $display("FAIL enable_drop_done got=%b exp=1 (timeout)", done); end
        vec++; if (cap_count - start_cap !== 4) begin errs++; $display("FAIL enable_drop_words got=%0d exp=4", cap_count - start_cap); end
        vec++; if (len !== 12'd14) begin errs++; $display("FAIL enable_drop_len got=%0d exp=14", len); end
        vec++; if (pkt_cnt !== 16'd5) begin errs++; $display("FAIL enable_drop_cnt got=%0d exp=5", pkt_cnt); end
        cpu_q_dma_pkt_avail = 1'b1;
        snap = rd_count;
        repeat (10) @(posedge clk);
        #1;
        vec++; if (rd_count !== snap) begin errs++; $display("FAIL enable_no_restart got=%0d exp=%0d", rd_count, snap); end
        cpu_q_dma_pkt_avail = 1'b0;
    endtask

    task automatic test_mid_reset();
        bit done; logic [11:0] len; logic err; int ns; int snap; int cyc;
        fill(8, 4'b0001, 32'h6000_0000);
        start_rd = rd_count;
        enable = 1'b1; cpu_q_dma_pkt_avail = 1'b1;
        cyc = 0;
        while (rd_count - start_rd < 3 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        vec++; if (rd_count - start_rd < 3) begin errs++; $display("FAIL mreset_started got=%0d exp>=3", rd_count - start_rd); end
        #2 reset_n = 1'b0;
        #1;
        vec++; if (cpu_q_dma_rd !== 1'b0) begin errs++; $display("FAIL mreset_rd got=%b exp=0", cpu_q_dma_rd); end
        vec++; if (xfer_vld !== 1'b0) begin errs++; $display("FAIL mreset_xfer_vld got=%b exp=0", xfer_vld); end
        vec++; if (xfer_last !== 1'b0) begin errs++; $display("FAIL mreset_xfer_last got=%b exp=0", xfer_last); end
        vec++; if (xfer_data !== 32'h0) begin errs++; $display("FAIL mreset_xfer_data got=%h exp=0", xfer_data); end
        vec++; if (pkt_len !== 12'h0) begin errs++; $display("FAIL mreset_pkt_len got=%0d exp=0", pkt_len); end
        vec++; if (pkt_cnt !== 16'h0) begin errs++; $display("FAIL mreset_pkt_cnt got=%0d exp=0", pkt_cnt); end
        vec++; if (pkt_len_vld !== 1'b0 || pkt_err !== 1'b0) begin errs++; $display("FAIL mreset_strobes got=%b%b exp=00", pkt_len_vld, pkt_err); end
        cpu_q_dma_pkt_avail = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        snap = rd_count;
        repeat (4) @(posedge clk);
        #1;
        vec++; if (rd_count !== snap) begin errs++; $display("FAIL mreset_idle_reads got=%0d exp=%0d", rd_count, snap); end
        vec++; if (pkt_cnt !== 16'h0) begin errs++; $display("FAIL mreset_cnt_after got=%0d exp=0", pkt_cnt); end
        run_pkt(2, 4'b0001, 32'h7000_0000, 1'b0, -1, -1, done, len, err, ns);
        vec++; if (done !== 1'b1) begin errs++; $display("FAIL mreset_recover_done got=%b exp=1 (timeout)", done); end
        vec++; if (len !== 12'd8) begin errs++; $display("FAIL mreset_recover_len got=%0d exp=8", len); end
        vec++; if (cap_data[start_cap] !== 32'h7000_0000) begin errs++; $display("FAIL mreset_recover_data got=%h exp=70000000", cap_data[start_cap]); end
        vec++; if (pkt_cnt !== 16'd1) begin errs++; $display("FAIL mreset_recover_cnt got=%0d exp=1", pkt_cnt); end
    endtask

    initial begin
        fill(1, 4'b0001, 32'h0);
        test_reset();
        test_basic();
        test_rdy_toggle();
        test_truncate();
        test_rd_stall();
        test_enable();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/dma_txq_pkt_reader.md
DMA_TXQ_PKT_READER -- requirements
Module: dma_txq_pkt_reader

Interface
REQ-001 SHALL have parameter DMA_DATA_WIDTH, default 32: queue and transfer data width.
REQ-002 SHALL have parameter DMA_CTRL_WIDTH, default DMA_DATA_WIDTH/8: queue ctrl width, one bit per byte.
REQ-003 SHALL have parameter MAX_PKT_WORDS, default 384: largest packet forwarded, in words (1536 bytes).
REQ-004 SHALL have ports, in this order:
- clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits starting a new packet.
- cpu_q_dma_pkt_avail  in  1  at least one whole packet is stored in the CPU queue.
- cpu_q_dma_rd_rdy  in  1  queue can accept a read this cycle.
- cpu_q_dma_rd  out  1  read strobe to the queue.
- cpu_q_dma_rd_data  in  DMA_DATA_WIDTH  queue word, valid the cycle after cpu_q_dma_rd.
- cpu_q_dma_rd_ctrl  in  DMA_CTRL_WIDTH  0 = middle word; non-zero = last word.
- xfer_data  out  DMA_DATA_WIDTH  word to the DMA engine.
- xfer_vld  out  1  xfer_data is valid.
- xfer_last  out  1  marks the final word of the packet.
- xfer_rdy  in  1  DMA engine accepts the word.
- pkt_len  out  12  byte length of the completed packet.
- pkt_len_vld  out  1  one-cycle strobe qualifying pkt_len and pkt_err.
- pkt_err  out  1  packet was truncated at MAX_PKT_WORDS.
- pkt_cnt  out  16  count of completed packets, wraps.

Function
REQ-005 SHALL implement FSM states IDLE, READ, DISCARD and DONE.
REQ-006 IDLE SHALL go to READ when enable & cpu_q_dma_pkt_avail & cpu_q_dma_rd_rdy are all 1; a word counter (wcnt) SHALL clear to 0 on this transition.
REQ-007 At most one queue read SHALL be outstanding at any time.
REQ-008 In READ, cpu_q_dma_rd SHALL assert only when all of the following hold:
- cpu_q_dma_rd_rdy=1;
- no read is outstanding;
- the end-of-packet word has not yet been received;
- the output register is empty, or is being accepted this cycle (xfer_vld & xfer_rdy).
REQ-009 Returned data SHALL load the output register the cycle after cpu_q_dma_rd; xfer_vld SHALL then be 1.
REQ-010 xfer_vld, xfer_data and xfer_last SHALL remain stable until xfer_vld & xfer_rdy are both 1.
REQ-011 wcnt SHALL increment on each returned word; it SHALL be wide enough to hold MAX_PKT_WORDS.
REQ-012 A word with cpu_q_dma_rd_ctrl != 0 SHALL set xfer_last=1.
REQ-013 Bytes in the last word SHALL be decoded from cpu_q_dma_rd_ctrl:
- 4'b1000 → 1;
- 4'b0100 → 2;
- 4'b0010 → 3;
- 4'b0001 → 4;
- any other non-zero value → 4.
REQ-014 pkt_len SHALL equal 4*(wcnt-1) + last-word bytes, computed in 12 bits.
REQ-015 When the returned word is number MAX_PKT_WORDS and its ctrl is 0:
- xfer_last SHALL be forced to 1;
- pkt_err SHALL be latched;
- pkt_len SHALL be 4*MAX_PKT_WORDS;
- the FSM SHALL go to DISCARD once that word is accepted.
REQ-016 DISCARD SHALL keep issuing reads (REQ-007/008 pacing, output-register condition ignored) and drop the data; it SHALL go to DONE when a word with ctrl != 0 returns.
REQ-017 READ SHALL go to DONE when the last word has been accepted by the DMA engine.
REQ-018 DONE SHALL last exactly one cycle:
- pkt_len_vld=1;
- pkt_cnt increments;
- next state is IDLE.
- pkt_err SHALL clear on leaving DONE.
REQ-019 Deasserting enable in READ or DISCARD SHALL NOT abort the packet; it only blocks the next start.
REQ-020 Deasserting cpu_q_dma_rd_rdy SHALL stall reads only; no state change and no data loss.
REQ-021 Back-to-back packets SHALL need at least one IDLE cycle between DONE and the next READ.

Reset
REQ-022 reset_n=0 SHALL immediately, asynchronously set:
- state to IDLE;
- cpu_q_dma_rd, xfer_vld, xfer_last, pkt_len_vld and pkt_err to 0;
- xfer_data, pkt_len, pkt_cnt and wcnt to 0;
- the outstanding-read flag to 0.
REQ-023 Reset during a packet SHALL abandon it; the unread remainder stays in the queue, and no recovery is required.
REQ-024 The first cpu_q_dma_rd after reset_n rises SHALL come no earlier than the second rising edge of clk.

Verification
REQ-025 3-word packet, ctrl 0,0,4'b0010, xfer_rdy held at 1 → three xfer words, last flagged; pkt_len=11, pkt_err=0, pkt_cnt=1.
REQ-026 Same packet with xfer_rdy toggling every cycle → identical data order, no duplicates or losses, at most one read outstanding.
REQ-027 400-word packet → exactly 384 words out, the 384th with xfer_last=1; 16 words drained; pkt_len=1536, pkt_err=1.
REQ-028 cpu_q_dma_rd_rdy low for 5 cycles mid-packet → reads pause, then resume; pkt_len correct.
REQ-029 enable=0 with pkt_avail=1 → no reads; enable dropped mid-packet → packet completes, next is not started.
REQ-030 reset_n pulsed low mid-packet → all outputs 0 during reset; FSM in IDLE and pkt_cnt=0 after release.
